trace_pkt_serializer: RTL and testbench

Consumer end of the core's instruction trace port. It accepts one `trace_pkt_t` per cycle carrying up to three retired or trapping instruction lanes. It splits the packet into per-instruction records, buffers them in a FIFO, and presents them one per cycle on a valid/ready stream to a trace sink (debug probe, trace memory, or testbench monitor). The core cannot be stalled, so the block has no input backpressure. Packets that do not fit are dropped whole and accounted for.

---
 rtl/trace_pkt_serializer.sv | 160 ++++++++++++++++
 tb/tb_trace_pkt_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_pkt_serializer.sv
// Trace packet serializer: splits up to three retired-instruction lanes per
// cycle into single records and streams them out through a small FIFO.
package trace_pkg;
  typedef struct packed {
    logic [2:0]  valid_ip;
    logic [95:0] insn_ip;
    logic [95:0] address_ip;
    logic [2:0]  exception_ip;
    logic [2:0]  interrupt_ip;
    logic [4:0]  ecause_ip;
    logic [31:0] tval_ip;
  } trace_pkt_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic [1:0]  lane;
  } trace_rec_t;
endpackage

module trace_pkt_serializer
  import trace_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  trace_pkt_t                 trace_pkt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_insn,
  output logic [31:0]                out_addr,
  output logic                       out_exc,
  output logic                       out_int,
  output logic [4:0]                 out_ecause,
  output logic [31:0]                out_tval,
  output logic [1:0]                 out_lane,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       ovf_sticky,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_rec_t            mem_q [DEPTH];
  trace_rec_t            rec   [3];
  trace_rec_t            head;
  logic [AW-1:0]         slot  [3];
  logic [AW-1:0]         wr_q, wr_d;
  logic [AW-1:0]         rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         n, free;
  logic                  accept, drop, pop;
  logic                  sticky_q, sticky_d;
  logic [DROP_CNT_W-1:0] dcnt_q, dcnt_d;

  always_comb begin
    n = '0;
    for (int k = 0; k < 3; k++) begin
      n = n + {{(CW-1){1'b0}}, trace_pkt.valid_ip[k]};
    end
    free   = CW'(DEPTH) - cnt_q;
    accept = (n <= free);
    drop   = (n != '0) && !accept;
    pop    = out_valid && out_ready;
  end

  // Valid lanes are packed densely in ascending lane order.
  always_comb begin
    slot[0] = '0;
    slot[1] = {{(AW-1){1'b0}}, trace_pkt.valid_ip[0]};
    slot[2] = slot[1] + {{(AW-1){1'b0}}, trace_pkt.valid_ip[1]};
    for (int k = 0; k < 3; k++) begin
      rec[k].insn   = trace_pkt.insn_ip[32*k +: 32];
      rec[k].addr   = trace_pkt.address_ip[32*k +: 32];
      rec[k].exc    = trace_pkt.exception_ip[k];
      rec[k].intr   = trace_pkt.interrupt_ip[k];
      rec[k].lane   = 2'(k);
      rec[k].ecause = '0;
      rec[k].tval   = '0;
      if (trace_pkt.exception_ip[k] || trace_pkt.interrupt_ip[k]) begin
        rec[k].ecause = trace_pkt.ecause_ip;
        rec[k].tval   = trace_pkt.tval_ip;
      end
    end
  end

  always_comb begin
    wr_d  = accept ? wr_q + n[AW-1:0] : wr_q;
    rd_d  = rd_q + {{(AW-1){1'b0}}, pop};
    cnt_d = cnt_q + (accept ? n : '0) - {{(CW-1){1'b0}}, pop};
  end

  always_comb begin
    sticky_d = sticky_q;
    dcnt_d   = dcnt_q;
    if (ovf_clr) begin
      sticky_d = 1'b0;
      dcnt_d   = '0;
    end
    if (drop) begin
      sticky_d = 1'b1;
      if (ovf_clr) begin
        dcnt_d = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
      end else if (!(&dcnt_q)) begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dcnt_q   <= dcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int k = 0; k < 3; k++) begin
        if (trace_pkt.valid_ip[k]) begin
          mem_q[wr_q + slot[k]] <= rec[k];
        end
      end
    end
  end

  always_comb begin
    out_valid = (cnt_q != '0);
    head      = out_valid ? mem_q[rd_q] : '0;
  end

  assign out_insn   = head.insn;
  assign out_addr   = head.addr;
  assign out_exc    = head.exc;
  assign out_int    = head.intr;
  assign out_ecause = head.ecause;
  assign out_tval   = head.tval;
  assign out_lane   = head.lane;
  assign fifo_count = cnt_q;
  assign ovf_sticky = sticky_q;
  assign drop_cnt   = dcnt_q;

endmodule

// File: tb/tb_trace_pkt_serializer.sv
// Scoreboard bench for trace_pkt_serializer: a queue-based reference model
// is fed at each clock and a negedge monitor compares the DUT head.
module tb_trace_pkt_serializer;
  import trace_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int CW    = 4;
  localparam int DMAX  = 15;

  typedef logic [104:0] rv_t;

  logic          clk = 1'b0;
  logic          rst;
  trace_pkt_t    pkt;
  logic          out_valid, out_ready;
  logic [31:0]   out_insn, out_addr, out_tval;
  logic          out_exc, out_int;
  logic [4:0]    out_ecause;
  logic [1:0]    out_lane;
  logic [CW-1:0] fifo_count;
  logic          ovf_sticky;
  logic [DW-1:0] drop_cnt;
  logic          ovf_clr;

  trace_pkt_serializer #(.DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rst(rst), .trace_pkt(pkt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_insn(out_insn), .out_addr(out_addr),
    .out_exc(out_exc), .out_int(out_int),
    .out_ecause(out_ecause), .out_tval(out_tval),
    .out_lane(out_lane), .fifo_count(fifo_count),
    .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  rv_t exp_q[$];
  bit  pend_pop, started, stall_prev;
  int  m_sticky, m_drop, n_in, used;
  rv_t act, prev_act;
  int  errors = 0;
  int  checks = 0;

  function automatic rv_t mk(logic [31:0] insn, logic [31:0] addr,
                             logic e, logic i, logic [4:0] c,
                             logic [31:0] tv, int lane);
    logic t;
    t = e | i;
    return {insn, addr, e, i, t ? c : 5'd0, t ? tv : 32'd0, 2'(lane)};
  endfunction

  task automatic chk(string name, rv_t a, rv_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  // Reference model: a packet either fits entirely or is dropped whole.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend_pop = 0;
      m_sticky = 0;
      m_drop   = 0;
      started  = 1;
    end else begin
      n_in     = $countones(pkt.valid_ip);
      used     = exp_q.size() + (pend_pop ? 1 : 0);
      pend_pop = 0;
      if (n_in > 0 && n_in > DEPTH - used) begin
        m_sticky = 1;
        m_drop   = ovf_clr ? 1 : (m_drop < DMAX ? m_drop + 1 : DMAX);
      end else begin
        if (ovf_clr) begin
          m_sticky = 0;
          m_drop   = 0;
        end
        for (int k = 0; k < 3; k++) begin
          if (pkt.valid_ip[k]) begin
            exp_q.push_back(mk(pkt.insn_ip[32*k +: 32],
                               pkt.address_ip[32*k +: 32],
                               pkt.exception_ip[k], pkt.interrupt_ip[k],
                               pkt.ecause_ip, pkt.tval_ip, k));
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      act = {out_insn, out_addr, out_exc, out_int,
             out_ecause, out_tval, out_lane};
      if (exp_q.size() > 0) begin
        chk("out_valid", rv_t'(out_valid), rv_t'(1));
        chk("head", act, exp_q[0]);
        if (stall_prev) chk("stable", act, prev_act);
        if (out_ready) begin
          void'(exp_q.pop_front());
          pend_pop = 1;
        end
      end else begin
        chk("out_valid_idle", rv_t'(out_valid), rv_t'(0));
        chk("idle_zero", act, rv_t'(0));
      end
      chk("fifo_count", rv_t'(fifo_count), rv_t'(exp_q.size() + (pend_pop ? 1 : 0)));
      chk("ovf_sticky", rv_t'(ovf_sticky), rv_t'(m_sticky));
      chk("drop_cnt", rv_t'(drop_cnt), rv_t'(m_drop));
      stall_prev = out_valid && !out_ready;
      prev_act   = act;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] v, logic [2:0] e, logic [2:0] i,
                       logic [4:0] c, logic [31:0] tv,
                       logic [31:0] base, logic [31:0] insn0);
    pkt.valid_ip     = v;
    pkt.exception_ip = e;
    pkt.interrupt_ip = i;
    pkt.ecause_ip    = c;
    pkt.tval_ip      = tv;
    for (int k = 0; k < 3; k++) begin
      pkt.insn_ip[32*k +: 32]    = insn0 + 32'(k);
      pkt.address_ip[32*k +: 32] = base + 32'(4 * k);
    end
    cyc();
    pkt = '0;
  endtask

  initial begin
    rst       = 1'b1;
    pkt       = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    drive(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h8000_0000, 32'h13);
    repeat (2) cyc();
    drive(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h100, 32'h0000_0093);
    chk("three_cnt", rv_t'(fifo_count), rv_t'(3));
    repeat (4) cyc();
    drive(3'b010, 3'b010, 3'b000, 5'd2, 32'hDEAD_BEEF, 32'h200, 32'h7300);
    drive(3'b010, 3'b000, 3'b000, 5'd2, 32'hDEAD_BEEF, 32'h300, 32'h7400);
    drive(3'b101, 3'b100, 3'b001, 5'd11, 32'h1234_5678, 32'h400, 32'h10);
    drive(3'b000, 3'b111, 3'b111, 5'd7, 32'hFFFF_0000, 32'h500, 32'h20);
    repeat (4) cyc();

    out_ready = 1'b0;
    drive(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h1000, 32'h1);
    drive(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h2000, 32'h2);
    drive(3'b100, 3'b000, 3'b000, 5'd0, 32'h0, 32'h3000, 32'h3);
    chk("fill7", rv_t'(fifo_count), rv_t'(7));
    drive(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h4000, 32'h4);
    chk("drop_keep7", rv_t'(fifo_count), rv_t'(7));
    chk("drop_one", rv_t'(drop_cnt), rv_t'(1));
    drive(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h5000, 32'h5);
    chk("fill8", rv_t'(fifo_count), rv_t'(8));
    drive(3'b010, 3'b000, 3'b000, 5'd0, 32'h0, 32'h6000, 32'h6);
    ovf_clr = 1'b1;
    drive(3'b001, 3'b000, 3'b000, 5'd0, 32'h0, 32'h7000, 32'h7);
    ovf_clr = 1'b0;
    chk("clr_collide", rv_t'(drop_cnt), rv_t'(1));
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    for (int j = 0; j < 20; j++) begin
      drive(3'b011, 3'b000, 3'b000, 5'd0, 32'h0, 32'h8000, 32'(j));
    end
    chk("saturate", rv_t'(drop_cnt), rv_t'(DMAX));
    out_ready = 1'b1;
    repeat (10) cyc();

    out_ready = 1'b0;
    drive(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'h9000, 32'h9);
    drive(3'b110, 3'b000, 3'b000, 5'd0, 32'h0, 32'hA000, 32'hA);
    chk("hold5", rv_t'(fifo_count), rv_t'(5));
    rst = 1'b1;
    drive(3'b111, 3'b000, 3'b000, 5'd0, 32'h0, 32'hB000, 32'hB);
    rst = 1'b0;
    chk("rst_cnt", rv_t'(fifo_count), rv_t'(0));
    chk("rst_valid", rv_t'(out_valid), rv_t'(0));
    out_ready = 1'b1;
    cyc();

    for (int j = 0; j < 800; j++) begin
      out_ready        = (j < 400) ? ($urandom_range(0, 3) == 0)
                                   : ($urandom_range(0, 3) != 0);
      ovf_clr          = ($urandom_range(0, 24) == 0);
      pkt.valid_ip     = 3'($urandom);
      pkt.exception_ip = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b0;
      pkt.interrupt_ip = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b0;
      pkt.ecause_ip    = 5'($urandom);
      pkt.tval_ip      = $urandom;
      pkt.insn_ip      = {$urandom, $urandom, $urandom};
      pkt.address_ip   = {$urandom, $urandom, $urandom};
      cyc();
    end
    pkt       = '0;
    ovf_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (12) cyc();
    chk("drained", rv_t'(fifo_count), rv_t'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
